// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the HI/LO multiply/divide unit: op encodings,
// default datapath width and the sequencer state type.
package mips_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic [2:0] MDU_MULT  = 3'b000;
  localparam logic [2:0] MDU_MULTU = 3'b001;
  localparam logic [2:0] MDU_DIV   = 3'b010;
  localparam logic [2:0] MDU_DIVU  = 3'b011;
  localparam logic [2:0] MDU_MTHI  = 3'b100;
  localparam logic [2:0] MDU_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter_datapath.sv
// Combinational single-iteration step (shift-add multiply or restoring divide)
// and the final sign correction applied when the result is committed.
module mdu_iter_datapath import mips_pkg::*; #(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic [2*WIDTH:0]  acc_i,
  input  logic [WIDTH-1:0]  b_i,
  input  logic              div_i,
  input  logic              neg_q_i,
  input  logic              neg_r_i,
  input  logic              dz_i,
  output logic [2*WIDTH:0]  step_o,
  output logic [WIDTH-1:0]  hi_o,
  output logic [WIDTH-1:0]  lo_o
);

  logic [WIDTH:0]     sum_s;
  logic [2*WIDTH:0]   shl_s;
  logic [WIDTH+1:0]   diff_s;
  logic [2*WIDTH-1:0] prod_s;

  // One iteration: acc holds {partial/remainder, multiplier/quotient bits}.
  always_comb begin
    sum_s  = '0;
    shl_s  = '0;
    diff_s = '0;
    step_o = acc_i;
    if (div_i) begin
      shl_s  = {acc_i[2*WIDTH-1:0], 1'b0};
      diff_s = {1'b0, shl_s[2*WIDTH:WIDTH]} - {2'b00, b_i};
      if (diff_s[WIDTH+1]) begin
        step_o = shl_s;
      end else begin
        step_o = {diff_s[WIDTH:0], shl_s[WIDTH-1:1], 1'b1};
      end
    end else begin
      sum_s  = acc_i[2*WIDTH:WIDTH] + ({1'b0, b_i} & {(WIDTH+1){acc_i[0]}});
      step_o = {1'b0, sum_s, acc_i[WIDTH-1:1]};
    end
  end

  // Sign correction; divide-by-zero leaves the remainder equal to the dividend.
  always_comb begin
    prod_s = '0;
    hi_o   = '0;
    lo_o   = '0;
    if (div_i) begin
      if (dz_i) begin
        lo_o = '1;
      end else if (neg_q_i) begin
        lo_o = -acc_i[WIDTH-1:0];
      end else begin
        lo_o = acc_i[WIDTH-1:0];
      end
      if (neg_r_i) begin
        hi_o = -acc_i[2*WIDTH-1:WIDTH];
      end else begin
        hi_o = acc_i[2*WIDTH-1:WIDTH];
      end
    end else begin
      if (neg_q_i) begin
        prod_s = -acc_i[2*WIDTH-1:0];
      end else begin
        prod_s = acc_i[2*WIDTH-1:0];
      end
      hi_o = prod_s[2*WIDTH-1:WIDTH];
      lo_o = prod_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: sequencer, iteration counter, operand
// registers and the architectural HI/LO registers.
module mult_div_unit import mips_pkg::*; #(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             flush,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic               div_q, div_d, neg_q_q, neg_q_d, neg_r_q, neg_r_d, dz_q, dz_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               s_rs_s, s_rt_s;
  logic [WIDTH-1:0]   abs_rs_s, abs_rt_s;
  logic [2*WIDTH:0]   step_s;
  logic [WIDTH-1:0]   fix_hi_s, fix_lo_s;

  mdu_iter_datapath #(.WIDTH(WIDTH)) u_dp (
    .acc_i   (acc_q),
    .b_i     (b_q),
    .div_i   (div_q),
    .neg_q_i (neg_q_q),
    .neg_r_i (neg_r_q),
    .dz_i    (dz_q),
    .step_o  (step_s),
    .hi_o    (fix_hi_s),
    .lo_o    (fix_lo_s)
  );

  // Signed ops (op[0] clear) latch magnitudes; unsigned ops latch raw values.
  always_comb begin
    s_rs_s   = ~op[0] & rs_data[WIDTH-1];
    s_rt_s   = ~op[0] & rt_data[WIDTH-1];
    abs_rs_s = s_rs_s ? -rs_data : rs_data;
    abs_rt_s = s_rt_s ? -rt_data : rt_data;
  end

  // Next-state: flush outranks start, iteration and commit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_d     = b_q;
    div_d   = div_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          case (op)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
              state_d = RUN;
              cnt_d   = '0;
              acc_d   = {{(WIDTH+1){1'b0}}, abs_rs_s};
              b_d     = abs_rt_s;
              div_d   = op[1];
              neg_q_d = s_rs_s ^ s_rt_s;
              neg_r_d = s_rs_s;
              dz_d    = (rt_data == '0);
            end
            MDU_MTHI: hi_d = rs_data;
            MDU_MTLO: lo_d = rs_data;
            default:  state_d = IDLE;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = step_s;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = FIX;
          end else begin
            state_d = RUN;
          end
        end
      end
      FIX: begin
        state_d = IDLE;
        cnt_d   = '0;
        if (!flush) begin
          hi_d   = fix_hi_s;
          lo_d   = fix_lo_s;
          done_d = 1'b1;
        end else begin
          done_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and architectural registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      div_q   <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      div_q   <= div_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit with hand-computed results.
module tb_mult_div_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] rs_data, rt_data, hi, lo;
  logic        busy, done;
  int          n_cmp = 0;
  int          n_err = 0;
  int          lat, bcnt, dcnt;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .flush   (flush),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int l, output int bc);
    l = 0; bc = 0;
    while (done !== 1'b1 && l < 60) begin
      if (busy === 1'b1) bc++;
      tick();
      l++;
    end
  endtask

  task automatic mdop(input string tag, input logic [2:0] o, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int l, bc;
    go(o, a, b);
    wait_done(l, bc);
    chk({tag, "_latency"}, l, 32'd33);
    chk({tag, "_busycycles"}, bc, 32'd33);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
    tick();
    chk({tag, "_done_drop"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'b000;
    rs_data = 32'd0; rt_data = 32'd0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);

    mdop("mult_m1x2",  MDU_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE);
    mdop("multu_m1x2", MDU_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE);
    mdop("div_m7by2",  MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    mdop("divu_7by0",  MDU_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF);
    mdop("div_ovf",    MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    mdop("div_100bym7",MDU_DIV,   32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2);

    // MTHI from idle: visible next cycle, no busy/done
    go(MDU_MTHI, 32'h12345678, 32'd0);
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    chk("mthi_done", {31'd0, done}, 32'd0);
    tick();
    chk("mthi_busy2", {31'd0, busy | done}, 32'd0);

    // MTLO held while a MULT is busy must be ignored
    go(MDU_MULT, 32'd3, 32'hFFFFFFFB);
    op = MDU_MTLO; rs_data = 32'hDEADBEEF; start = 1'b1;
    wait_done(lat, bcnt);
    start = 1'b0;
    chk("mtlo_busy_latency", lat, 32'd33);
    chk("mtlo_busy_hi", hi, 32'hFFFFFFFF);
    chk("mtlo_busy_lo", lo, 32'hFFFFFFF1);
    tick();
    chk("mtlo_busy_lo_hold", lo, 32'hFFFFFFF1);

    // Back-to-back: second start in the done cycle
    go(MDU_MULTU, 32'd6, 32'd7);
    wait_done(lat, bcnt);
    chk("b2b_first_lo", lo, 32'd42);
    go(MDU_MULTU, 32'h00010000, 32'h00010000);
    chk("b2b_accept_busy", {31'd0, busy}, 32'd1);
    wait_done(lat, bcnt);
    chk("b2b_done_spacing", lat + 1, 32'd34);
    chk("b2b_hi", hi, 32'd1);
    chk("b2b_lo", lo, 32'd0);

    // Flush at busy cycle 10 of a DIV
    go(MDU_MTHI, 32'hA5A5A5A5, 32'd0);
    go(MDU_MTLO, 32'hA5A5A5A5, 32'd0);
    go(MDU_DIV, 32'd100, 32'd7);
    repeat (9) tick();
    chk("flush_busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) dcnt++;
      tick();
    end
    chk("flush_no_done", dcnt, 32'd0);
    chk("flush_hi", hi, 32'hA5A5A5A5);
    chk("flush_lo", lo, 32'hA5A5A5A5);

    // Reserved ops and flush-in-idle do nothing
    go(3'b110, 32'h11111111, 32'd1);
    chk("rsv110_busy", {31'd0, busy}, 32'd0);
    go(3'b111, 32'h11111111, 32'd1);
    chk("rsv111_busy", {31'd0, busy}, 32'd0);
    chk("rsv_hi", hi, 32'hA5A5A5A5);
    chk("rsv_lo", lo, 32'hA5A5A5A5);
    flush = 1'b1;
    go(MDU_MULT, 32'd3, 32'd5);
    flush = 1'b0;
    chk("idle_flush_blocks", {31'd0, busy}, 32'd0);

    // Reset mid-RUN
    go(MDU_MULT, 32'd3, 32'd5);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    mdop("mult_3x5", MDU_MULT, 32'd3, 32'd5, 32'd0, 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative HI/LO multiply/divide unit for the MIPS core. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO on the two operands delivered by the register file read ports (rs, rt). It owns the architectural HI and LO registers and raises `busy` so the pipeline stalls until a result is ready. MFHI and MFLO read the `hi` and `lo` outputs directly.

## Interface
- Parameter `WIDTH`, default 32: operand and HI/LO width.
- `clk` input, 1 bit: single clock; all state updates on its rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: request to execute `op` this cycle.
- `op` input, 3 bits: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are reserved and do nothing.
- `flush` input, 1 bit: cancel any in-flight operation.
- `rs_data` input, WIDTH: first operand (multiplicand, dividend, or MTHI/MTLO source).
- `rt_data` input, WIDTH: second operand (multiplier or divisor).
- `busy` output, 1 bit: an operation is in flight; new starts are ignored.
- `done` output, 1 bit: one-cycle pulse when HI/LO have just been updated by a mult/div.
- `hi` output, WIDTH: architectural HI register.
- `lo` output, WIDTH: architectural LO register.

## Operation
- States:
  - IDLE: waits for a start.
  - RUN: iterates, with a 5-bit counter.
  - FIX: applies sign correction and commits.
- Accept: `start` is sampled in IDLE with `flush` low.
  - MTHI or MTLO: write `rs_data` to HI or LO at the accept edge. Stay in IDLE. `busy` and `done` stay low.
  - MULT, MULTU, DIV or DIVU: latch the operands at the accept edge and go to RUN.
- Signed ops (MULT, DIV): latch |rs| and |rt| as unsigned values and record the sign flags.
- Unsigned ops (MULTU, DIVU): latch the raw operand values.
- Multiply: radix-2 shift-add, one bit per cycle, 64-bit product.
- Divide: restoring, one quotient bit per cycle.
  - Quotient goes to LO, remainder to HI.
  - Quotient sign is sign(rs) XOR sign(rt); remainder sign is sign(rs).
- Divide by zero, signed or unsigned: HI = `rs_data` as latched, LO = all ones. Takes the full normal latency.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Signed multiply: the product is negated when sign(rs) XOR sign(rt) is set.
- `start` while `busy`: ignored, with no queueing. The pipeline holds the instruction until `busy` falls.
- `flush`:
  - In RUN or FIX: return to IDLE at that edge, with HI/LO unchanged and no `done`.
  - In IDLE: blocks any start in the same cycle.
- Reserved op with `start`: no state change.

## Timing
- Edge E0: accept the op and enter RUN, counter = 0.
- Edges E1–E32: one iteration each. E32 moves the state to FIX.
- Edge E33: HI/LO written, state returns to IDLE.
- `busy` is high from after E0 through E33 (33 cycles). It is registered, not combinational on `start`.
- `done` is high for exactly the one cycle after E33.
- A new `start` is accepted at E34 at the earliest, i.e. in the cycle `done` is high.
- MTHI/MTLO are visible on `hi`/`lo` the cycle after the accept edge.
- Reset values on any `rst` edge, including mid-operation: state IDLE, `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, counter = 0.
- `rst` has priority over `flush`, and `flush` has priority over `start`.

## Structure
- Shared package `mips_pkg` holds:
  - the `op` encodings (MDU_MULT through MDU_MTLO);
  - the WIDTH constant;
  - the state enum (IDLE, RUN, FIX).
- Sub-module `mdu_iter_datapath` holds the combinational single-step logic: shift-add step, restore-subtract step, and the final negate. The top level keeps the FSM, counter, operand registers and HI/LO.

## Test plan
- MULT rs=0xFFFFFFFF, rt=0x00000002:
  - after 33 busy cycles: `done` pulses, HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - MULTU with the same operands: HI=0x00000001, LO=0xFFFFFFFE.
- Divides:
  - DIV rs=0xFFFFFFF9 (-7), rt=2: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU rs=7, rt=0: LO=0xFFFFFFFF, HI=7, with the same 33-cycle latency.
- MTHI rs=0x12345678 from idle: `hi`=0x12345678 next cycle, `busy` and `done` never assert. Then MTLO with `start` held while busy from a MULT: ignored, `lo` holds the MULT result.
- Back-to-back: start a second MULTU in the cycle `done` is high: accepted, and its `done` occurs exactly 34 cycles after the first `done`.
- `flush` at cycle 10 of a DIV: `busy` falls next cycle, no `done`, HI/LO keep their prior values (preload via MTHI/MTLO = 0xA5A5A5A5).
- `rst` asserted mid-RUN: the next cycle shows `hi`=`lo`=0 and `busy`=`done`=0. A subsequent MULT 3×5 gives LO=15, HI=0.
